// File: rtl/uart_tx_fifo.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   UART transmitter with an internal baud-rate clock enable and a small TX
//   FIFO in front of the shift register. Frames are start bit, DATA_BITS data
//   bits sent LSB first, an optional parity bit, then STOP_BITS stop bits. Every
//   bit is held for DIV = CLK_FREQ / BAUDRATE cycles of clk.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active high
//   tx_data     byte to queue
//   tx_valid    tx_data is valid; push = tx_valid && tx_ready at posedge clk
//   tx_ready    FIFO has room for another byte
//   fifo_count  bytes waiting in the FIFO (the byte being shifted is excluded)
//   busy        a frame is in progress or bytes are still queued
//   tx          serial line, idle high, driven from a flop
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUDRATE   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_BITS-1:0]            tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            busy,
    output logic                            tx
);

    localparam int DIV = CLK_FREQ / BAUDRATE;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int BW  = $clog2(STOP_BITS * DIV + 1);
    localparam int IW  = $clog2(DATA_BITS);

    localparam logic [BW-1:0] BIT_RELOAD  = BW'(DIV - 1);
    localparam logic [BW-1:0] STOP_RELOAD = BW'(STOP_BITS * DIV - 1);
    localparam logic [IW-1:0] LAST_BIT    = IW'(DATA_BITS - 1);
    localparam logic [CW-1:0] FULL        = CW'(FIFO_DEPTH);
    localparam logic          ODD_PARITY  = (PARITY == 1);

    // Elaboration-time parameter sanity checks.
    if (DIV < 2) begin : g_div_check
        $error("uart_tx_fifo: CLK_FREQ/BAUDRATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_check
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_parity_check
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [BW-1:0]          baud_cnt;
    logic [IW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shifter;
    logic                   parity_bit;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [DATA_BITS-1:0]   head;
    logic                   fifo_empty;
    logic                   bit_done;
    logic                   push;
    logic                   pop;

    assign head       = mem[rd_ptr];
    assign fifo_empty = (fifo_count == '0);
    assign bit_done   = (baud_cnt == '0);
    assign tx_ready   = (fifo_count < FULL);
    assign push       = tx_valid && tx_ready;
    // A byte leaves the FIFO either from idle or on the very last stop-bit
    // cycle, which is what makes queued frames run back to back.
    assign pop        = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && bit_done));
    assign busy       = (state != S_IDLE) || !fifo_empty;

    // NOTE: the storage array carries no reset; only the pointers and count
    // define which entries are live, so clearing the data would buy nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // NOTE: every clocked block uses non-blocking assignments so that all
    // flops sample the pre-edge values, whatever the block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer. baud_cnt is loaded with DIV-1 (or STOP_BITS*DIV-1 for
    // the stop phase) when a bit is launched, so each bit lasts exactly DIV
    // cycles and the bit advances on the cycle the counter reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shifter    <= '0;
            parity_bit <= 1'b0;
        end else if (pop) begin
            shifter    <= head;
            parity_bit <= (^head) ^ ODD_PARITY;
            baud_cnt   <= BIT_RELOAD;
            tx         <= 1'b0;
            state      <= S_START;
        end else if (state != S_IDLE && !bit_done) begin
            baud_cnt <= baud_cnt - BW'(1);
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                end
                S_START: begin
                    tx       <= shifter[0];
                    bit_idx  <= '0;
                    baud_cnt <= BIT_RELOAD;
                    state    <= S_DATA;
                end
                S_DATA: begin
                    if (bit_idx != LAST_BIT) begin
                        tx       <= shifter[1];
                        shifter  <= shifter >> 1;
                        bit_idx  <= bit_idx + IW'(1);
                        baud_cnt <= BIT_RELOAD;
                    end else if (PARITY != 0) begin
                        tx       <= parity_bit;
                        baud_cnt <= BIT_RELOAD;
                        state    <= S_PARITY;
                    end else begin
                        tx       <= 1'b1;
                        baud_cnt <= STOP_RELOAD;
                        state    <= S_STOP;
                    end
                end
                S_PARITY: begin
                    tx       <= 1'b1;
                    baud_cnt <= STOP_RELOAD;
                    state    <= S_STOP;
                end
                S_STOP: begin
                    // Last stop cycle with nothing queued.
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo at DIV = 10. Four instances cover 8N1,
//   8E1, 8O1 and 7N2; sel routes the shared stimulus to one of them and muxes
//   its outputs back. Inputs change and outputs are sampled on negedge clk.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CF  = 1_000_000;
    localparam int BR  = 100_000;
    localparam int DIV = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    int         sel;

    logic [3:0] vld_w;
    logic [3:0] tx_w;
    logic [3:0] rdy_w;
    logic [3:0] busy_w;
    logic [2:0] cnt_w [4];

    logic       tx_m;
    logic       ready_m;
    logic       busy_m;
    logic [2:0] count_m;

    int n_vec  = 0;
    int n_miss = 0;

    logic cap_tx   [0:700];
    logic cap_busy [0:700];

    always #5 clk = ~clk;

    assign vld_w   = valid ? (4'b0001 << sel) : 4'b0000;
    assign tx_m    = tx_w[sel];
    assign ready_m = rdy_w[sel];
    assign busy_m  = busy_w[sel];
    assign count_m = cnt_w[sel];

    uart_tx_fifo #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_valid(vld_w[0]),
        .tx_ready(rdy_w[0]), .fifo_count(cnt_w[0]), .busy(busy_w[0]), .tx(tx_w[0]));

    uart_tx_fifo #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_valid(vld_w[1]),
        .tx_ready(rdy_w[1]), .fifo_count(cnt_w[1]), .busy(busy_w[1]), .tx(tx_w[1]));

    uart_tx_fifo #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .tx_data(data), .tx_valid(vld_w[2]),
        .tx_ready(rdy_w[2]), .fifo_count(cnt_w[2]), .busy(busy_w[2]), .tx(tx_w[2]));

    uart_tx_fifo #(.CLK_FREQ(CF), .BAUDRATE(BR), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .tx_data(data[6:0]), .tx_valid(vld_w[3]),
        .tx_ready(rdy_w[3]), .fifo_count(cnt_w[3]), .busy(busy_w[3]), .tx(tx_w[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // 8N1 line pattern, bit 0 = start bit.
    function automatic logic [15:0] frame_8n1(input logic [7:0] b);
        return {6'd0, 1'b1, b, 1'b0};
    endfunction

    // Called at a negedge; holds valid until the byte is accepted.
    task automatic push(input logic [7:0] d);
        int guard;
        data  = d;
        valid = 1'b1;
        guard = 0;
        while (!ready_m && guard < 300) begin
            guard++;
            @(negedge clk);
        end
        check("push_ready", {31'd0, ready_m}, 32'd1);
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Waits for the start bit, then records tx/busy for samples 0..n.
    task automatic capture(input string tag, input int n, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx_m !== 1'b0 && waited < 300);
        check({tag, "_start"}, {31'd0, tx_m}, 32'd0);
        cap_tx[0]   = tx_m;
        cap_busy[0] = busy_m;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            cap_tx[i]   = tx_m;
            cap_busy[i] = busy_m;
        end
    endtask

    // Checks the first and last cycle of each bit cell against the pattern.
    task automatic check_bits(input string tag, input int base, input logic [15:0] bits,
                              input int nbits);
        for (int i = 0; i < nbits; i++) begin
            check($sformatf("%s_bit%0d", tag, i),
                  {30'd0, cap_tx[base + i*DIV], cap_tx[base + i*DIV + DIV - 1]},
                  {30'd0, bits[i], bits[i]});
        end
    endtask

    task automatic check_end(input string tag, input int len);
        check({tag, "_busy_last"}, {31'd0, cap_busy[len-1]}, 32'd1);
        check({tag, "_busy_after"}, {31'd0, cap_busy[len]}, 32'd0);
        check({tag, "_tx_after"}, {31'd0, cap_tx[len]}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int stall;
        logic [7:0] t6_bytes [5];

        rst   = 1'b1;
        data  = 8'h00;
        valid = 1'b0;
        sel   = 0;

        // Reset state of every instance.
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #0;
            check($sformatf("rst_tx_%0d", s), {31'd0, tx_m}, 32'd1);
            check($sformatf("rst_ready_%0d", s), {31'd0, ready_m}, 32'd1);
            check($sformatf("rst_busy_%0d", s), {31'd0, busy_m}, 32'd0);
            check($sformatf("rst_count_%0d", s), {29'd0, count_m}, 32'd0);
        end
        sel = 0;
        rst = 1'b0;
        @(negedge clk);

        // 1. 8N1 0x30, latency, timing and busy fall.
        push(8'h30);
        check("t1_tx_before", {31'd0, tx_m}, 32'd1);
        check("t1_count_q", {29'd0, count_m}, 32'd1);
        check("t1_busy_q", {31'd0, busy_m}, 32'd1);
        capture("t1", 100, w);
        check("t1_latency", w, 32'd1);
        check_bits("t1", 0, frame_8n1(8'h30), 10);
        check_end("t1", 100);

        // 2. Even parity (bit 1) and odd parity (bit 0) for 0x07.
        sel = 1;
        @(negedge clk);
        push(8'h07);
        capture("t2e", 110, w);
        check_bits("t2e", 0, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        check_end("t2e", 110);
        sel = 2;
        @(negedge clk);
        push(8'h07);
        capture("t2o", 110, w);
        check_bits("t2o", 0, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        check_end("t2o", 110);

        // 4. 7 data bits, 2 stop bits.
        sel = 3;
        @(negedge clk);
        push(8'h7F);
        capture("t4", 100, w);
        check_bits("t4", 0, {6'd0, 2'b11, 7'h7F, 1'b0}, 10);
        check_end("t4", 100);

        // 3. Six consecutive pushes: back-pressure and a contiguous stream.
        sel = 0;
        @(negedge clk);
        fork
            begin
                for (int b = 1; b <= 5; b++) begin
                    data  = 8'(b);
                    valid = 1'b1;
                    @(negedge clk);
                end
                check("t3_count_full", {29'd0, count_m}, 32'd4);
                check("t3_ready_low", {31'd0, ready_m}, 32'd0);
                data  = 8'h06;
                stall = 0;
                while (!ready_m && stall < 300) begin
                    stall++;
                    @(negedge clk);
                end
                check("t3_stall", stall, 32'd97);
                @(negedge clk);
                valid = 1'b0;
            end
            begin
                capture("t3", 600, w);
            end
        join
        for (int f = 0; f < 6; f++) begin
            check_bits($sformatf("t3_f%0d", f), f*100, frame_8n1(8'(f + 1)), 10);
        end
        check_end("t3", 600);

        // 6. Push on the end-of-frame pop edge with the FIFO one short of full.
        t6_bytes[0] = 8'h11;
        t6_bytes[1] = 8'h22;
        t6_bytes[2] = 8'h33;
        t6_bytes[3] = 8'h44;
        t6_bytes[4] = 8'hC5;
        @(negedge clk);
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    data  = t6_bytes[b];
                    valid = 1'b1;
                    @(negedge clk);
                end
                valid = 1'b0;
                check("t6_count_pre", {29'd0, count_m}, 32'd3);
                repeat (97) @(negedge clk);
                data  = t6_bytes[4];
                valid = 1'b1;
                @(negedge clk);
                valid = 1'b0;
                check("t6_count_same_edge", {29'd0, count_m}, 32'd3);
            end
            begin
                capture("t6", 500, w);
            end
        join
        for (int f = 0; f < 5; f++) begin
            check_bits($sformatf("t6_f%0d", f), f*100, frame_8n1(t6_bytes[f]), 10);
        end
        check_end("t6", 500);

        // 5. Reset at cycle 35 of a frame with two bytes queued.
        @(negedge clk);
        data  = 8'h00;
        valid = 1'b1;
        @(negedge clk);
        data  = 8'hAA;
        @(negedge clk);
        data  = 8'hBB;
        @(negedge clk);
        valid = 1'b0;
        repeat (34) @(negedge clk);
        check("t5_tx_pre", {31'd0, tx_m}, 32'd0);
        check("t5_count_pre", {29'd0, count_m}, 32'd2);
        rst = 1'b1;
        #1;
        check("t5_tx_rst", {31'd0, tx_m}, 32'd1);
        check("t5_count_rst", {29'd0, count_m}, 32'd0);
        check("t5_busy_rst", {31'd0, busy_m}, 32'd0);
        check("t5_ready_rst", {31'd0, ready_m}, 32'd1);
        data  = 8'h99;
        valid = 1'b1;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        check("t5_push_in_rst", {29'd0, count_m}, 32'd0);
        check("t5_tx_in_rst", {31'd0, tx_m}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        push(8'h55);
        capture("t5", 100, w);
        check("t5_latency", w, 32'd1);
        check_bits("t5", 0, frame_8n1(8'h55), 10);
        check_end("t5", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
